// File: rtl/sseg_pkg.sv
// Digit codes, segment glyphs and the glyph lookup shared by the 4-digit
// seven-segment scanner.
package sseg_pkg;

    // 0-15 are hex digits, 16 is minus, 17 is blank
    typedef logic [4:0] dcode_t;

    localparam dcode_t D_MINUS = 5'd16;
    localparam dcode_t D_BLANK = 5'd17;

    localparam logic [6:0] G_0     = 7'h40;
    localparam logic [6:0] G_1     = 7'h79;
    localparam logic [6:0] G_2     = 7'h24;
    localparam logic [6:0] G_3     = 7'h30;
    localparam logic [6:0] G_4     = 7'h19;
    localparam logic [6:0] G_5     = 7'h12;
    localparam logic [6:0] G_6     = 7'h02;
    localparam logic [6:0] G_7     = 7'h78;
    localparam logic [6:0] G_8     = 7'h00;
    localparam logic [6:0] G_9     = 7'h10;
    localparam logic [6:0] G_A     = 7'h08;
    localparam logic [6:0] G_B     = 7'h03;
    localparam logic [6:0] G_C     = 7'h46;
    localparam logic [6:0] G_D     = 7'h21;
    localparam logic [6:0] G_E     = 7'h06;
    localparam logic [6:0] G_F     = 7'h0E;
    localparam logic [6:0] G_MINUS = 7'h3F;
    localparam logic [6:0] G_BLANK = 7'h7F;

    function automatic logic [6:0] glyph(input dcode_t d);
        case (d)
            5'd0:    glyph = G_0;
            5'd1:    glyph = G_1;
            5'd2:    glyph = G_2;
            5'd3:    glyph = G_3;
            5'd4:    glyph = G_4;
            5'd5:    glyph = G_5;
            5'd6:    glyph = G_6;
            5'd7:    glyph = G_7;
            5'd8:    glyph = G_8;
            5'd9:    glyph = G_9;
            5'd10:   glyph = G_A;
            5'd11:   glyph = G_B;
            5'd12:   glyph = G_C;
            5'd13:   glyph = G_D;
            5'd14:   glyph = G_E;
            5'd15:   glyph = G_F;
            D_MINUS: glyph = G_MINUS;
            default: glyph = G_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/sseg4_tdm_bin_to_bcd.sv
// Combinational double-dabble: 14-bit binary (0..9999) to four BCD nibbles.
module bin_to_bcd (
    input  logic [13:0]     bin,
    output logic [3:0][3:0] bcd
);

    logic [15:0] acc;

    always_comb begin
        acc = '0;
        for (int i = 13; i >= 0; i--) begin
            for (int n = 0; n < 4; n++) begin
                if (acc[n*4 +: 4] >= 4'd5)
                    acc[n*4 +: 4] = acc[n*4 +: 4] + 4'd3;
            end
            acc = {acc[14:0], bin[i]};
        end
        bcd = acc;
    end

endmodule

// File: rtl/sseg4_tdm.sv
// Four-digit common-anode seven-segment driver: hex / unsigned / signed
// decimal formatting in stage 1, time-multiplexed anode and glyph in stage 2.
module sseg4_tdm
    import sseg_pkg::*;
#(
    parameter int REFRESH_BITS = 18
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] data,
    input  logic        hex_dec,
    input  logic        sign,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    logic [REFRESH_BITS-1:0] cnt;
    logic [1:0]              idx;
    logic [15:0]             mag;
    logic [13:0]             dec_val;
    logic [3:0][3:0]         bcd;
    dcode_t [3:0]            d_next;
    dcode_t [3:0]            d_q;

    assign idx = cnt[REFRESH_BITS-1 -: 2];

    bin_to_bcd u_bcd (
        .bin (dec_val),
        .bcd (bcd)
    );

    // 16'h8000 negates to itself, which read unsigned is the wanted 32768
    always_comb begin
        mag = data[15] ? (~data + 16'd1) : data;
        if (sign)
            dec_val = (mag > 16'd999) ? 14'd999 : mag[13:0];
        else
            dec_val = (data > 16'd9999) ? 14'd9999 : data[13:0];

        d_next = '0;
        for (int i = 0; i < 4; i++) begin
            if (hex_dec)
                d_next[i] = {1'b0, data[i*4 +: 4]};
            else
                d_next[i] = {1'b0, bcd[i]};
        end
        if (!hex_dec && sign)
            d_next[3] = data[15] ? D_MINUS : D_BLANK;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt <= '0;
            d_q <= {4{D_BLANK}};
            an  <= 4'hF;
            seg <= G_BLANK;
            dp  <= 1'b1;
        end else begin
            cnt <= cnt + REFRESH_BITS'(1);
            d_q <= d_next;
            an  <= ~(4'b0001 << idx);
            seg <= glyph(d_q[idx]);
            dp  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sseg4_tdm.sv
// Scoreboard bench for sseg4_tdm: stimulus queues expected (cycle, an, seg)
// entries, a negedge monitor pops and compares them and checks dp every cycle.
module tb_sseg4_tdm;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] data;
    logic        hex_dec;
    logic        sign;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    sseg4_tdm #(.REFRESH_BITS(4)) dut (
        .clock   (clock),
        .reset   (reset),
        .data    (data),
        .hex_dec (hex_dec),
        .sign    (sign),
        .seg     (seg),
        .dp      (dp),
        .an      (an)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [6:0] seg;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   e_cyc   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        exp_t e;
        n_tests++;
        if (dp !== 1'b1) begin
            n_fail++;
            $display("FAIL dp_off cyc=%0d got=%b want=1", cyc, dp);
        end
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_tests++;
            if (e.cyc != cyc || an !== e.an || seg !== e.seg) begin
                n_fail++;
                $display("FAIL %s cyc=%0d (want cyc %0d) got an=%b seg=%h want an=%b seg=%h",
                         e.nm, cyc, e.cyc, an, seg, e.an, e.seg);
            end
        end
    end

    task automatic push(input int c, input logic [3:0] a, input logic [6:0] s, input string nm);
        exp_t e;
        e.cyc = c; e.an = a; e.seg = s; e.nm = nm;
        sb.push_back(e);
    endtask

    // expected anode / glyph for cycles from..to, scan phase measured from e_cyc
    task automatic push_scan(input int from, input int to, input logic [3:0][6:0] g, input string nm);
        for (int m = from; m <= to; m++) begin
            int         idx;
            logic [3:0] a;
            idx    = ((m - e_cyc) >> 2) & 3;
            a      = 4'hF;
            a[idx] = 1'b0;
            push(m, a, g[idx], nm);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    task automatic set_and_check(input logic [15:0] d, input logic hx, input logic sg,
                                 input logic [3:0][6:0] g, input string nm);
        int c;
        data = d; hex_dec = hx; sign = sg;
        c = cyc;
        push_scan(c + 2, c + 17, g, nm);
        wait_cyc(c + 17);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        reset   = 1'b0;
        data    = 16'hA5C3;
        hex_dec = 1'b1;
        sign    = 1'b0;
        for (int i = 1; i <= 3; i++) push(i, 4'hF, 7'h7F, "reset_state");
        wait_cyc(3);

        // release: stage-1 registers still blank on the first cycle
        reset = 1'b1;
        e_cyc = 4;
        push(4, 4'b1110, 7'h7F, "first_after_reset");
        push_scan(5, 23, {7'h08, 7'h12, 7'h46, 7'h30}, "hex_A5C3");
        wait_cyc(23);

        // reset mid-scan, then scanning restarts at digit 0
        c = cyc;
        reset = 1'b0;
        push(c + 1, 4'hF, 7'h7F, "mid_reset");
        wait_cyc(c + 1);
        reset = 1'b1;
        e_cyc = c + 2;
        push(c + 2, 4'b1110, 7'h7F, "resume_digit0");
        push_scan(c + 3, c + 10, {7'h08, 7'h12, 7'h46, 7'h30}, "resume_hex");
        wait_cyc(c + 10);

        set_and_check(16'hBEEF, 1'b1, 1'b1, {7'h03, 7'h06, 7'h06, 7'h0E}, "hex_sign_ignored");
        set_and_check(16'd1234, 1'b0, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, "udec_1234");
        set_and_check(16'd12345, 1'b0, 1'b0, {7'h10, 7'h10, 7'h10, 7'h10}, "udec_sat");
        set_and_check(16'hFFFF, 1'b0, 1'b0, {7'h10, 7'h10, 7'h10, 7'h10}, "udec_ffff_sat");
        set_and_check(16'hFF85, 1'b0, 1'b1, {7'h3F, 7'h79, 7'h24, 7'h30}, "sdec_m123");
        set_and_check(16'h8000, 1'b0, 1'b1, {7'h3F, 7'h10, 7'h10, 7'h10}, "sdec_min_sat");
        set_and_check(16'd1000, 1'b0, 1'b1, {7'h7F, 7'h10, 7'h10, 7'h10}, "sdec_pos_sat");
        set_and_check(16'd42, 1'b0, 1'b1, {7'h7F, 7'h40, 7'h19, 7'h24}, "sdec_42");

        // change data while digit 0 is lit: old glyph one cycle on, new glyph after two
        while (((cyc - e_cyc) % 16) != 15) @(negedge clock);
        c = cyc;
        data = 16'd7;
        push(c + 1, 4'b1110, 7'h24, "latency_old");
        push(c + 2, 4'b1110, 7'h78, "latency_new");
        wait_cyc(c + 2);

        wait_cyc(cyc + 3);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s never checked, want cyc %0d an=%b seg=%h", e.nm, e.cyc, e.an, e.seg);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sseg4_tdm.md
Name: sseg4_tdm

Overview:
- Drives a 4-digit, common-anode seven-segment display by time-division multiplexing (TDM): one digit is lit at a time and the digits rotate fast enough to look steady.
- Shows a 16-bit value in one of three modes: hex, unsigned decimal, or signed decimal.
- Used as the display back-end for timers and counters; the board-level wrapper ties the unused anodes high.

Parameters:
- REFRESH_BITS, 18, width of the free-running refresh counter. Bits [REFRESH_BITS-1:REFRESH_BITS-2] select the active digit (about 381 Hz full scan at 100 MHz). Benches use 4.

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous reset, active-low.
- data  input  16  value to display.
- hex_dec  input  1  1 = hex mode, 0 = decimal mode.
- sign  input  1  decimal mode only: 1 = treat data as two's complement.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low; held at 1 (off).
- an  output  4  digit anodes, active-low, one-hot-low; an[0] is the rightmost digit.

Behaviour:
- Reset (reset==0 at a clock edge): refresh counter = 0, digit-code registers = blank, an = 4'b1111, seg = 7'h7F, dp = 1.
- Refresh counter: increments every cycle and wraps to 0.
  - idx = counter[REFRESH_BITS-1:REFRESH_BITS-2].
  - Each digit is active for 2^(REFRESH_BITS-2) cycles.
  - Scan order is digit 0, 1, 2, 3, then repeat.
- Stage 1 (registered every cycle) computes four digit codes d3..d0 from data, hex_dec and sign:
  - Hex mode (hex_dec=1): d3..d0 = data[15:12], [11:8], [7:4], [3:0]. sign is ignored.
  - Unsigned decimal (hex_dec=0, sign=0): binary-to-BCD conversion. If data > 9999, saturate to 9999. Leading zeros are shown.
  - Signed decimal (hex_dec=0, sign=1):
    - mag = |data| as two's complement, with 16'h8000 giving magnitude 32768.
    - mag saturates at 999 and is shown on d2..d0.
    - d3 = minus if data[15]==1, otherwise blank.
- Stage 2 (registered every cycle):
  - an = all ones except an[idx] = 0.
  - seg = glyph(d[idx]).
  - dp = 1.
- Latency: a data change reaches seg 2 cycles later, provided that digit is active. an follows idx with 1 cycle of latency.
- Glyphs (seg hex, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10
  - A=08, b=03, C=46, d=21, E=06, F=0E
  - minus=3F, blank=7F
- Mode or data changes mid-scan take effect on the next stage-1 update. There is no glitch protection beyond the two-stage registering.
- Reset asserted mid-scan returns the block to the reset state at the next edge. Scanning resumes at digit 0.

Decomposition:
- Package sseg_pkg:
  - 5-bit digit-code typedef: values 0-15 are hex glyphs, 16 = minus, 17 = blank.
  - The glyph constants listed above.
  - A glyph() lookup function.
- One sub-module, bin_to_bcd: combinational double-dabble, 14-bit input (0..9999), four BCD nibbles out.
- Saturation and sign handling stay in sseg4_tdm.

Test Plan (REFRESH_BITS=4, 4 cycles per digit):
- Reset held low for 3 cycles -> an=1111, seg=7F, dp=1. After release, an[0] goes low on the first cycle after release and an rotates 1110, 1101, 1011, 0111, 1110 every 4 cycles.
- hex_dec=1, data=16'hA5C3 -> across one scan, seg = 30 (3), 46 (C), 12 (5), 08 (A) on an[0..3] respectively.
- hex_dec=0, sign=0, data=1234 -> digits 4,3,2,1 (seg 19, 30, 24, 79). With data=12345, the display saturates to 9999 (all four seg = 10).
- hex_dec=0, sign=1, data=16'hFF85 (-123) -> d3 = minus (3F), d2..d0 = 1,2,3. With data=16'h8000, the display shows minus 999.
- hex_dec=0, sign=1, data=42 -> d3 blank (7F), d2..d0 = 0,4,2. Change data to 7 while digit 0 is active -> seg shows 78 exactly 2 cycles later.
- Verify dp==1 for every cycle of the test.
